// File: rtl/alu_sequencer.sv
// Command sequencer for an external registered ALU: queues operand/op commands in a FIFO,
// issues them one at a time and returns each result through a valid/ready response port.
module alu_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [3:0] cmd_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_select,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_err,
    output logic [3:0] rsp_op,
    output logic       busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] b;
        logic [7:0] a;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop, fifo_empty;
    cmd_t             head;

    state_e state_q, state_d;
    logic   capture, rsp_clear, div_zero;

    logic [7:0] alu_a_q, alu_b_q, rsp_data_q;
    logic [3:0] alu_select_q, op_q, rsp_op_q;
    logic       rsp_valid_q, rsp_carry_q, rsp_err_q;

    // Ready depends on count only, so a same-cycle pop never frees a slot for a push.
    assign cmd_ready  = (count_q != CNT_W'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: cmd_op, b: cmd_b, a: cmd_a};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        capture   = 1'b0;
        rsp_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue:   state_d = StCapture;
            StCapture: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign div_zero = (op_q == 4'b0011) && (alu_b_q == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_select_q <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_op_q     <= '0;
        end else begin
            if (pop) begin
                alu_a_q      <= head.a;
                alu_b_q      <= head.b;
                alu_select_q <= head.op;
                op_q         <= head.op;
            end
            // Payload is left untouched on handshake; only valid drops.
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= div_zero ? 8'hFF : alu_result;
                rsp_carry_q <= (op_q == 4'b0000) && alu_carry;
                rsp_err_q   <= div_zero;
                rsp_op_q    <= op_q;
            end else if (rsp_clear) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = alu_select_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_op     = rsp_op_q;
    assign busy       = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small registered-ALU model attached to its ALU port.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [3:0] cmd_op;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_select;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry, rsp_err;
    logic [3:0] rsp_op;
    logic       busy;
    logic [8:0] alu_sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .rsp_op     (rsp_op),
        .busy       (busy)
    );

    // ALU model: registered result, combinational add carry. Divide by zero returns 0 here.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        logic [15:0] p;
        p = a * b;
        case (op)
            4'd0:    alu_fn = a + b;
            4'd1:    alu_fn = a - b;
            4'd2:    alu_fn = p[7:0];
            4'd3:    alu_fn = (b == 8'd0) ? 8'd0 : a / b;
            4'd4:    alu_fn = a & b;
            4'd5:    alu_fn = a | b;
            4'd6:    alu_fn = a ^ b;
            4'd10:   alu_fn = {a[6:0], a[7]};
            4'd15:   alu_fn = {7'd0, a == b};
            default: alu_fn = 8'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_result <= 8'd0;
        else        alu_result <= alu_fn(alu_a, alu_b, alu_select);
    end

    assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_carry = alu_sum[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that accepted the command.
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int waited;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Waits for rsp_valid, checks the payload, then lets the next edge complete the handshake.
    task automatic expect_rsp(input string tag, input logic [7:0] data, input logic carry,
                              input logic err, input logic [3:0] op, input int lat_exp);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, rsp_data}, {24'd0, data});
        check({tag, "_carry"}, {31'd0, rsp_carry}, {31'd0, carry});
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, err});
        check({tag, "_op"}, {28'd0, rsp_op}, {28'd0, op});
        if (lat_exp >= 0) check({tag, "_latency"}, lat, lat_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;
        cmd_valid = 1'b0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_op    = 4'd0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_regs", {12'd0, alu_a, alu_b, alu_select}, 32'd0);
        check("rst_rsp_payload", {18'd0, rsp_data, rsp_carry, rsp_err, rsp_op}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single add: 200+100 = 300 -> 44 with carry, valid on 3rd edge after accept.
        send_cmd(8'd200, 8'd100, 4'd0);
        expect_rsp("add", 8'd44, 1'b1, 1'b0, 4'd0, 3);
        check("add_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("add_done_busy", {31'd0, busy}, 32'd0);

        send_cmd(8'd9, 8'd0, 4'd3);
        expect_rsp("div0", 8'hFF, 1'b0, 1'b1, 4'd3, 3);
        send_cmd(8'd9, 8'd2, 4'd3);
        expect_rsp("div", 8'd4, 1'b0, 1'b0, 4'd3, 3);
        send_cmd(8'd16, 8'd17, 4'd2);
        expect_rsp("mul", 8'h10, 1'b0, 1'b0, 4'd2, 3);

        // Backpressure: first command goes in flight, the next four fill the FIFO.
        rsp_ready = 1'b0;
        send_cmd(8'd10, 8'd3, 4'd1);
        send_cmd(8'd3, 8'd4, 4'd2);
        send_cmd(8'd6, 8'd3, 4'd4);
        send_cmd(8'h81, 8'h80, 4'd10);
        send_cmd(8'd5, 8'd5, 4'd15);
        check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("full_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_data", {24'd0, rsp_data}, 32'd7);
        check("hold_op", {28'd0, rsp_op}, 32'd1);

        // Full FIFO with handshake and push offered together: pop wins, push lands next edge.
        cmd_a     = 8'd250;
        cmd_b     = 8'd10;
        cmd_op    = 4'd0;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("refused_push_ready", {31'd0, cmd_ready}, 32'd1);
        check("handshake_clears_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("late_push_full", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        expect_rsp("bp_mul", 8'd12, 1'b0, 1'b0, 4'd2, -1);
        expect_rsp("bp_and", 8'd2, 1'b0, 1'b0, 4'd4, 2);
        expect_rsp("bp_rol", 8'h03, 1'b0, 1'b0, 4'd10, 2);
        expect_rsp("bp_eq", 8'd1, 1'b0, 1'b0, 4'd15, 2);
        expect_rsp("bp_add", 8'd4, 1'b1, 1'b0, 4'd0, 2);
        check("drain_busy", {31'd0, busy}, 32'd0);

        // Reset during CAPTURE with a second command still queued.
        send_cmd(8'd1, 8'd2, 4'd0);
        send_cmd(8'd3, 8'd4, 4'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_alu_a", {24'd0, alu_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("no_stale_rsp", {31'd0, seen}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        send_cmd(8'd7, 8'd8, 4'd0);
        expect_rsp("recover", 8'd15, 1'b0, 1'b0, 4'd0, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, >=2).
- REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge.
- REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-004 SHALL have port cmd_valid, input, 1, command offered.
- REQ-005 SHALL have port cmd_ready, output, 1, FIFO can accept a command.
- REQ-006 SHALL have ports cmd_a and cmd_b, input, 8 each, operands.
- REQ-007 SHALL have port cmd_op, input, 4, ALU select code (0000 add ... 1111 equal).
- REQ-008 SHALL have ports alu_a and alu_b, output, 8 each, registered operands driven to ALU A/B.
- REQ-009 SHALL have port alu_select, output, 4, registered select driven to the ALU.
- REQ-010 SHALL have port alu_result, input, 8, ALU registered result.
- REQ-011 SHALL have port alu_carry, input, 1, ALU combinational add carry.
- REQ-012 SHALL have port rsp_valid, output, 1, response available.
- REQ-013 SHALL have port rsp_ready, input, 1, consumer accepts response.
- REQ-014 SHALL have ports rsp_data (8), rsp_carry (1), rsp_err (1), rsp_op (4), all outputs, response payload.
- REQ-015 SHALL have port busy, output, 1, high when the FIFO is non-empty or the FSM is not IDLE.

Function
- REQ-016 SHALL accept a command on any edge where cmd_valid && cmd_ready; cmd_ready = (FIFO count != DEPTH), combinational from count only.
- REQ-017 SHALL NOT accept a push when full, even if a pop occurs in the same cycle.
- REQ-018 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
- REQ-019 In IDLE with FIFO non-empty: pop the head, load alu_a/alu_b/alu_select and a held op copy, go to ISSUE.
- REQ-020 ISSUE SHALL last exactly one cycle (ALU samples its operands on the exiting edge), then go to CAPTURE.
- REQ-021 CAPTURE SHALL last one cycle; on the exiting edge, register rsp_data <= alu_result, rsp_carry, rsp_err, rsp_op, set rsp_valid = 1, go to RESP.
- REQ-022 rsp_carry SHALL equal alu_carry when op = 0000, else 0.
- REQ-023 When op = 0011 and operand B = 0: rsp_err = 1 and rsp_data = 8'hFF; otherwise rsp_err = 0.
- REQ-024 alu_a/alu_b/alu_select SHALL remain stable from ISSUE entry until the next pop.
- REQ-025 In RESP: hold all rsp_* stable while rsp_valid && !rsp_ready; on handshake, clear rsp_valid, or (FIFO non-empty) pop and load the next command and go to ISSUE in the same edge, else go to IDLE.
- REQ-026 Latency: a command accepted into an empty FIFO in IDLE SHALL raise rsp_valid on the 3rd edge after the accept edge; with rsp_ready held high, throughput SHALL be one response per 3 cycles.
- REQ-027 Responses SHALL be issued in acceptance order; FIFO pointers SHALL wrap modulo DEPTH.
- REQ-028 Arithmetic results SHALL be the ALU's 8-bit truncated values, passed through unmodified except per REQ-023.

Reset
- REQ-029 While rst_n = 0: FSM = IDLE, FIFO empty, alu_a/alu_b/alu_select = 0, rsp_data/rsp_carry/rsp_err/rsp_op/rsp_valid = 0, busy = 0, cmd_ready = 1.
- REQ-030 Reset asserted mid-operation SHALL discard queued and in-flight commands; no response for them SHALL appear after release.

Verification
- REQ-031 Add: A=200, B=100, op=0000, rsp_ready=1 -> rsp_data=8'd44, rsp_carry=1, rsp_err=0, rsp_valid on the 3rd edge after accept.
- REQ-032 Divide by zero: A=9, B=0, op=0011 -> rsp_data=8'hFF, rsp_err=1, rsp_carry=0; then A=9, B=2, op=0011 -> rsp_data=4, rsp_err=0.
- REQ-033 Backpressure: rsp_ready=0, push 5 commands (10-3 sub, 3*4 mul, 6&3, 0x81 rotate-left, 5==5); cmd_ready SHALL drop after the 5th accept; release rsp_ready -> responses 7, 12, 2, 0x03, 1 in order.
- REQ-034 Multiply truncation: A=16, B=17, op=0010 -> rsp_data=8'h10, rsp_carry=0.
- REQ-035 Reset mid-op: rst_n low during CAPTURE -> rsp_valid=0, busy=0, cmd_ready=1 immediately; no response after release.
- REQ-036 Simultaneous: FIFO full, in RESP, rsp_ready=1, cmd_valid=1 -> pop occurs, push refused that cycle, accepted the next cycle.
